psum_collector: RTL
===================

// Module: psum_collector
// PURPOSE
// Parametrised serial-to-parallel collector for PE partial sums. Accepts OC words on one
// valid/ready input lane and presents them together on a flat MAX_CH-word output bus.
// Successor of the fixed 24x16-bit collector: adds a start/handshake protocol, reset,
// config checking, and an accumulate mode that sums psums across passes.
// Sits between PE psum output and the GLB write-back path.
// PARAMETERS
// DATA_W   16  word width; signed two's complement in accumulate mode
// MAX_CH   24  number of output slots (max filters per PE)
// CNT_W    5   width of oc/count fields; must satisfy 2**CNT_W > MAX_CH
// PORTS
// clk        in   1               rising-edge clock
// rst        in   1               async active-high reset
// start      in   1               pulse: begin a frame (sampled in IDLE only)
// oc         in   CNT_W           words in this frame; latched on accepted start
// acc_mode   in   1               latched on start; 1 = add into slots, 0 = overwrite
// clr        in   1               zero all slots (honoured in IDLE only)
// in_valid   in   1               input word valid
// in_data    in   DATA_W          input word
// in_ready   out  1               collector accepts a word this cycle
// out_valid  out  1               frame complete, out_data stable
// out_ready  in   1               consumer takes the frame
// out_data   out  MAX_CH*DATA_W   slot k at bits [k*DATA_W +: DATA_W]
// out_oc     out  CNT_W           latched oc of the presented frame
// busy       out  1               state != IDLE
// cfg_err    out  1               1-cycle pulse: start with oc==0 or oc>MAX_CH
// sat        out  1               sticky per frame: an accumulate saturated
// BEHAVIOUR
// - Reset: state IDLE, all slots 0, idx 0, oc_q 0, acc_q 0; in_ready, out_valid, busy,
//   cfg_err, sat all 0; out_oc 0. Reset mid-frame discards the frame.
// - FSM IDLE -> LOAD -> DONE -> IDLE.
// - IDLE: start with 1<=oc<=MAX_CH -> LOAD next cycle; latch oc_q, acc_q, idx=0, sat=0.
//   If acc_mode=0, slots 0..MAX_CH-1 zeroed in the same edge. Invalid oc -> cfg_err
//   pulse next cycle, stay IDLE, slots untouched. clr and valid start in the same cycle:
//   clr applies first (slots zero), then the frame starts.
// - LOAD: in_ready=1. Each beat (in_valid & in_ready) writes slot[idx], idx++.
//   Overwrite: slot=in_data. Accumulate: slot=sat(slot+in_data), signed DATA_W+1 sum
//   clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp sets sat.
//   Beat with idx==oc_q-1 -> DONE next cycle; in_ready drops the same cycle state leaves
//   LOAD, so no beat is accepted beyond oc_q. Gaps (in_valid=0) stall indefinitely.
// - Ordering: slot k holds the k-th accepted word (slot 0 = first).
// - DONE: out_valid=1, out_data/out_oc held stable until out_valid & out_ready; then IDLE
//   next cycle. out_ready in the first DONE cycle gives a 1-cycle DONE.
// - Latency: last input beat -> out_valid high 1 cycle later. Min frame period oc+2 cycles.
// - Slots k>=oc_q: 0 in overwrite mode; hold prior contents in accumulate mode.
// - start/clr outside IDLE ignored; cfg_err never fires outside IDLE.
// - out_data is registered (slot flops drive it directly); slots persist in IDLE so
//   accumulate frames chain. oc_q and acc_q do not change until next accepted start.
// TESTING
// 1 Reset then start oc=3 acc=0, send 0x0011,0x0022,0x0033 back-to-back -> out_valid
//   1 cycle after 3rd beat; slots0..2=0x0011,0x0022,0x0033, slots3..23=0, out_oc=3.
// 2 Frame oc=24 with in_valid toggling every other cycle, out_ready held 0 for 5 cycles
//   -> exactly 24 beats accepted, out_data stable throughout DONE, IDLE after handshake.
// 3 Frame oc=2 overwrite {100,-5}, then oc=2 acc=1 {50,5} -> slots {150,0}, sat=0;
//   then acc {0x7FF0,0} onto 0x7FFF-near value -> slot0=0x7FFF, sat=1.
// 4 start oc=0 and oc=25 -> cfg_err 1-cycle pulse each, busy stays 0, slots unchanged.
// 5 Assert rst mid-LOAD after 2 of 4 beats -> all outputs 0 at once, slots 0;
//   new start oc=1 completes normally.
// 6 start and clr during LOAD/DONE -> ignored; clr in IDLE -> all slots 0 next cycle.

Source files
------------

// File: rtl/psum_collector_if.sv
// Bundle of the psum collector's frame control, input lane and output bus.
// The master modport is the frame driver/consumer side; the slave is the collector.
interface psum_collector_if #(
    parameter int DATA_W = 16,
    parameter int MAX_CH = 24,
    parameter int CNT_W  = 5
);
    logic                       start;
    logic [CNT_W-1:0]           oc;
    logic                       acc_mode;
    logic                       clr;
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [MAX_CH*DATA_W-1:0]   out_data;
    logic [CNT_W-1:0]           out_oc;
    logic                       busy;
    logic                       cfg_err;
    logic                       sat;

    modport master (
        output start, oc, acc_mode, clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_oc, busy, cfg_err, sat
    );
    modport slave (
        input  start, oc, acc_mode, clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_oc, busy, cfg_err, sat
    );
endinterface

// File: rtl/psum_collector.sv
// Serial-to-parallel PE partial-sum collector: gathers oc words into MAX_CH slots,
// optionally accumulating (saturating) onto the previous frame's contents.
module psum_collector #(
    parameter int DATA_W = 16,
    parameter int MAX_CH = 24,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    psum_collector_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] MAX_OC = CNT_W'(MAX_CH);

    logic [1:0]                     state;
    logic [CNT_W-1:0]               idx;
    logic [CNT_W-1:0]               oc_q;
    logic                           acc_q;
    logic                           sat_q;
    logic                           cfg_err_q;
    logic [MAX_CH-1:0][DATA_W-1:0]  slot;

    logic              in_idle, oc_ok, go, zero_all, beat, last;
    logic [DATA_W-1:0] cur, sat_val, wdata;
    logic [DATA_W:0]   sum;
    logic              ovf;

    assign in_idle  = (state == IDLE);
    assign oc_ok    = (bus.oc != '0) && (bus.oc <= MAX_OC);
    assign go       = in_idle & bus.start & oc_ok;
    // clr ranks ahead of a same-cycle start, so both just zero the slots here
    assign zero_all = in_idle & (bus.clr | (go & ~bus.acc_mode));
    assign beat     = (state == LOAD) & bus.in_valid;
    assign last     = beat & (idx == oc_q - 1'b1);

    // One shared adder: select the slot being written, then saturate the sum
    always_comb begin
        cur = '0;
        for (int k = 0; k < MAX_CH; k++)
            if (idx == CNT_W'(k)) cur = slot[k];
    end

    assign sum     = {cur[DATA_W-1], cur} + {bus.in_data[DATA_W-1], bus.in_data};
    assign ovf     = sum[DATA_W] ^ sum[DATA_W-1];
    assign sat_val = !ovf ? sum[DATA_W-1:0]
                   : (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
    assign wdata   = acc_q ? sat_val : bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else begin
            for (int k = 0; k < MAX_CH; k++) begin
                if (zero_all)
                    slot[k] <= '0;
                else if (beat && idx == CNT_W'(k))
                    slot[k] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            oc_q      <= '0;
            acc_q     <= 1'b0;
            sat_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= in_idle & bus.start & ~oc_ok;
            case (state)
                IDLE: if (go) begin
                    state <= LOAD;
                    oc_q  <= bus.oc;
                    acc_q <= bus.acc_mode;
                    idx   <= '0;
                    sat_q <= 1'b0;
                end
                LOAD: if (beat) begin
                    idx <= idx + 1'b1;
                    if (acc_q && ovf) sat_q <= 1'b1;
                    if (last) state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = !in_idle;
    assign bus.out_data  = slot;
    assign bus.out_oc    = oc_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.sat       = sat_q;
endmodule
